// File: rtl/grid_display_scan.sv
// Row-scan driver for an 8x8 LED matrix fed from the Game of Life generation register.
// The grid is snapshotted once per frame so a mid-scan generation update never tears the image.
module grid_display_scan #(
  parameter int DWELL = 1000,
  parameter int BLANK = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [63:0] grid,
  output logic [7:0]  row_sel,
  output logic [7:0]  col_data,
  output logic [2:0]  row_idx,
  output logic        frame_done
);

  // state | meaning
  // IDLE  | outputs off, waiting for enable
  // LOAD  | one cycle: snapshot grid, restart at row 0
  // DRIVE | row_idx driven for DWELL cycles
  // BLANK | all rows off for BLANK cycles between rows
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRIVE = 2'd2,
    S_BLANK = 2'd3
  } state_t;

  localparam int CMAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_LAST = (BLANK > 0) ? CW'(BLANK - 1) : '0;

  state_t        state_q, state_d;
  logic [2:0]    row_q, row_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   snap_q, snap_d;
  logic [7:0]    row_sel_q, row_sel_d;
  logic [7:0]    col_data_q, col_data_d;
  logic          frame_done_q, frame_done_d;
  logic          end_row;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      row_q        <= '0;
      cnt_q        <= '0;
      snap_q       <= '0;
      row_sel_q    <= '0;
      col_data_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      cnt_q        <= cnt_d;
      snap_q       <= snap_d;
      row_sel_q    <= row_sel_d;
      col_data_q   <= col_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    cnt_d        = cnt_q;
    snap_d       = snap_q;
    frame_done_d = 1'b0;
    end_row      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_LOAD;
      end
      S_LOAD: begin
        snap_d  = grid;
        row_d   = '0;
        cnt_d   = '0;
        state_d = S_DRIVE;
      end
      S_DRIVE: begin
        if (cnt_q == DWELL_LAST) begin
          cnt_d = '0;
          if (BLANK > 0) state_d = S_BLANK;
          else           end_row = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          cnt_d   = '0;
          end_row = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (end_row) begin
      if (row_q == 3'd7) begin
        row_d        = '0;
        frame_done_d = 1'b1;
        state_d      = enable ? S_LOAD : S_IDLE;
      end else begin
        row_d   = row_q + 3'd1;
        state_d = S_DRIVE;
      end
    end
  end

  // Outputs are precomputed from the next state so they change on the same edge as the state.
  always_comb begin
    row_sel_d  = '0;
    col_data_d = '0;
    if (state_d == S_DRIVE) begin
      row_sel_d  = 8'b1 << row_d;
      col_data_d = snap_d[{row_d, 3'b000} +: 8];
    end
  end

  assign row_sel    = row_sel_q;
  assign col_data   = col_data_q;
  assign row_idx    = row_q;
  assign frame_done = frame_done_q;

endmodule
